// File: rtl/bch_ctrl_pkg.sv
// Shared widths, state encoding and the BCH(31,21) shortened-code helper
// used by the sequential dual-block decoder controller.
package bch_ctrl_pkg;

  localparam int BLK_W  = 26;  // one shortened BCH block
  localparam int DATA_W = 16;  // data bits per block
  localparam int PAR_W  = 10;  // parity bits per block
  localparam int WORD_W = 52;  // two blocks
  localparam int OUT_W  = 32;  // two data fields

  // g(x) = (x^5+x^2+1)(x^5+x^4+x^3+x^2+1), double-error-correcting
  localparam logic [PAR_W:0] GEN_POLY = 11'h769;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DEC_LO = 2'd1,
    DEC_HI = 2'd2,
    DONE   = 2'd3
  } bch_ctrl_state_t;

  // Remainder of v(x) modulo g(x); zero for every valid codeword.
  function automatic logic [PAR_W-1:0] bch_rem(input logic [BLK_W-1:0] v);
    logic [BLK_W-1:0] r;
    r = v;
    for (int k = BLK_W - 1; k >= PAR_W; k--) begin
      if (r[k]) begin
        r = r ^ (BLK_W'(GEN_POLY) << (k - PAR_W));
      end
    end
    return r[PAR_W-1:0];
  endfunction

endpackage

// File: rtl/bch_31_top.sv
// Combinational decoder for one 26-bit shortened BCH block (16 data + 10
// parity). Corrects up to two bit errors; reports any non-zero syndrome.
module bch_31_top
  import bch_ctrl_pkg::*;
(
  input  logic [BLK_W-1:0]  i_code,
  output logic [DATA_W-1:0] o_data,
  output logic              o_error_detected
);

  logic [PAR_W-1:0]  w_syn;
  logic [DATA_W-1:0] w_flip;

  assign w_syn = bch_rem(i_code);

  // A data bit flips when the syndrome matches that bit alone, or that bit
  // paired with any other position. Code distance 5 keeps these patterns
  // unique, so at most the true error positions ever match.
  genvar gi, gj;
  generate
    for (gi = PAR_W; gi < BLK_W; gi++) begin : g_bit
      localparam logic [PAR_W-1:0] REM_I = bch_rem(BLK_W'(1) << gi);
      logic [BLK_W-1:0] w_pair_hit;
      for (gj = 0; gj < BLK_W; gj++) begin : g_pair
        localparam logic [PAR_W-1:0] REM_J = bch_rem(BLK_W'(1) << gj);
        if (gj == gi) begin : g_self
          assign w_pair_hit[gj] = (w_syn == REM_I);
        end else begin : g_other
          assign w_pair_hit[gj] = (w_syn == (REM_I ^ REM_J));
        end
      end
      assign w_flip[gi-PAR_W] = |w_pair_hit;
    end
  endgenerate

  assign o_data           = i_code[BLK_W-1:PAR_W] ^ w_flip;
  assign o_error_detected = |w_syn;

endmodule

// File: rtl/bch_32_bits_seq_ctrl.sv
// Time-shares one bch_31_top between the low and high block of a 52-bit
// protected word, returning 32 corrected data bits over valid/ready and
// keeping a saturating count of delivered words that carried errors.
module bch_32_bits_seq_ctrl
  import bch_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  word_out,
  output logic              err_lo,
  output logic              err_hi,
  output logic              error_detected,
  input  logic              clr_count,
  output logic [CNT_W-1:0]  err_count
);

  bch_ctrl_state_t   r_state;
  bch_ctrl_state_t   w_state_next;
  logic [WORD_W-1:0] r_hold;
  logic [OUT_W-1:0]  r_word;
  logic              r_err_lo;
  logic              r_err_hi;
  logic              r_error_detected;
  logic [CNT_W-1:0]  r_count;

  logic [BLK_W-1:0]  w_dec_in;
  logic [DATA_W-1:0] w_dec_data;
  logic              w_dec_err;
  logic              w_deliver;

  bch_31_top u_dec (
    .i_code           (w_dec_in),
    .o_data           (w_dec_data),
    .o_error_detected (w_dec_err)
  );

  // Next state, handshake outputs and decoder input select.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_dec_in     = r_hold[BLK_W-1:0];
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = DEC_LO;
        end
      end
      DEC_LO: begin
        w_state_next = DEC_HI;
      end
      DEC_HI: begin
        w_dec_in     = r_hold[WORD_W-1:BLK_W];
        w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_deliver = out_valid & out_ready;

  // State, holding register, per-block result capture and error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_hold           <= '0;
      r_word           <= '0;
      r_err_lo         <= 1'b0;
      r_err_hi         <= 1'b0;
      r_error_detected <= 1'b0;
      r_count          <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && in_valid) begin
        r_hold <= data_in;
      end
      if (r_state == DEC_LO) begin
        r_word[DATA_W-1:0] <= w_dec_data;
        r_err_lo           <= w_dec_err;
      end
      if (r_state == DEC_HI) begin
        r_word[OUT_W-1:DATA_W] <= w_dec_data;
        r_err_hi               <= w_dec_err;
        r_error_detected       <= r_err_lo | w_dec_err;
      end
      // clear takes priority over a coincident increment
      if (clr_count) begin
        r_count <= '0;
      end else if (w_deliver && r_error_detected && r_count != '1) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign word_out       = r_word;
  assign err_lo         = r_err_lo;
  assign err_hi         = r_err_hi;
  assign error_detected = r_error_detected;
  assign err_count      = r_count;

endmodule
